// File: rtl/complex_mul_pipe_if.sv
// Stream interface for the pipelined complex multiplier.
// The master drives the operands and downstream ready; the slave (multiplier) returns the product.
interface complex_mul_pipe_if #(
  parameter int DATA_W = 8
);
  logic                  i_valid;
  logic                  o_ready;
  logic [2*DATA_W-1:0]   i_A;
  logic [2*DATA_W-1:0]   i_B;
  logic                  i_conj;
  logic                  o_valid;
  logic                  i_ready;
  logic [2*DATA_W-1:0]   o_prod;
  logic                  o_ovf;

  modport master (
    output i_valid, i_A, i_B, i_conj, i_ready,
    input  o_ready, o_valid, o_prod, o_ovf
  );

  modport slave (
    input  i_valid, i_A, i_B, i_conj, i_ready,
    output o_ready, o_valid, o_prod, o_ovf
  );
endinterface

// File: rtl/complex_mul_pipe.sv
// Three-stage pipelined signed fixed-point complex multiplier (FFT twiddle multiply).
// Stage 1 registers operands, stage 2 registers the four partial products,
// stage 3 combines, rounds half toward +inf, saturates and registers the result.
// All stages advance together on en = !o_valid || i_ready, so a stalled output holds everything.
module complex_mul_pipe #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 7
) (
  input logic             i_clk,
  input logic             i_rst_n,
  complex_mul_pipe_if.slave bus
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 1;

  localparam logic signed [SW-1:0] ROUND_K = SW'(1) <<< (FRAC_W - 1);
  localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (DATA_W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic en;

  logic signed [DATA_W-1:0] s1_ar, s1_ai, s1_br, s1_bi;
  logic                     s1_conj, s1_valid;

  logic signed [PW-1:0]     s2_rr, s2_ii, s2_ri, s2_ir;
  logic                     s2_conj, s2_valid;

  logic                     out_valid;
  logic [PW-1:0]            out_prod;
  logic                     out_ovf;

  logic signed [SW-1:0]     re_sum, im_sum, re_rnd, im_rnd;
  logic [DATA_W-1:0]        re_sat, im_sat;
  logic                     re_clip, im_clip;

  // Clamp a rounded value into the component range; top bit of the result flags a clip.
  function automatic logic [DATA_W:0] saturate(input logic signed [SW-1:0] v);
    logic [DATA_W:0] r;
    if (v > SAT_MAX)      r = {1'b1, SAT_MAX[DATA_W-1:0]};
    else if (v < SAT_MIN) r = {1'b1, SAT_MIN[DATA_W-1:0]};
    else                  r = {1'b0, v[DATA_W-1:0]};
    return r;
  endfunction

  assign en          = !out_valid || bus.i_ready;
  assign bus.o_ready = en;
  assign bus.o_valid = out_valid;
  assign bus.o_prod  = out_prod;
  assign bus.o_ovf   = out_ovf;

  // Stage 1: capture operand components, conjugate select and valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_conj  <= 1'b0;
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_br    <= '0;
      s1_bi    <= '0;
    end else if (en) begin
      s1_valid <= bus.i_valid;
      s1_conj  <= bus.i_conj;
      s1_ar    <= bus.i_A[PW-1:DATA_W];
      s1_ai    <= bus.i_A[DATA_W-1:0];
      s1_br    <= bus.i_B[PW-1:DATA_W];
      s1_bi    <= bus.i_B[DATA_W-1:0];
    end
  end

  // Stage 2: the four full-width signed partial products.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_conj  <= 1'b0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_conj  <= s1_conj;
      s2_rr    <= PW'(s1_ar) * PW'(s1_br);
      s2_ii    <= PW'(s1_ai) * PW'(s1_bi);
      s2_ri    <= PW'(s1_ar) * PW'(s1_bi);
      s2_ir    <= PW'(s1_ai) * PW'(s1_br);
    end
  end

  // Combine products one bit wider than a product, round, then saturate each component.
  always_comb begin
    re_sum  = '0;
    im_sum  = '0;
    re_rnd  = '0;
    im_rnd  = '0;
    re_sat  = '0;
    im_sat  = '0;
    re_clip = 1'b0;
    im_clip = 1'b0;
    if (s2_conj) begin
      re_sum = SW'(s2_rr) + SW'(s2_ii);
      im_sum = SW'(s2_ir) - SW'(s2_ri);
    end else begin
      re_sum = SW'(s2_rr) - SW'(s2_ii);
      im_sum = SW'(s2_ri) + SW'(s2_ir);
    end
    re_rnd = (re_sum + ROUND_K) >>> FRAC_W;
    im_rnd = (im_sum + ROUND_K) >>> FRAC_W;
    {re_clip, re_sat} = saturate(re_rnd);
    {im_clip, im_sat} = saturate(im_rnd);
  end

  // Stage 3: output register, held while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_prod  <= {re_sat, im_sat};
      out_ovf   <= re_clip | im_clip;
    end
  end

endmodule

// File: tb/tb_complex_mul_pipe.sv
// Self-checking bench for complex_mul_pipe (DATA_W=8, FRAC_W=7).
// Hand-computed vector table, conj-alternating burst, random backpressure stream and mid-stream reset.
module tb_complex_mul_pipe;
  localparam int DW = 8;
  localparam int FW = 7;

  logic i_clk;
  logic i_rst_n;
  int   checks = 0;
  int   errors = 0;

  complex_mul_pipe_if #(.DATA_W(DW)) bus ();

  complex_mul_pipe #(.DATA_W(DW), .FRAC_W(FW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          conj;
    logic [15:0] prod;
    bit          ovf;
  } vec_t;

  vec_t vecs[10];

  logic [15:0] st_a[32];
  logic [15:0] st_b[32];
  bit          st_c[32];
  logic [15:0] st_prod[32];
  bit          st_ovf[32];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input bit conj, input bit valid);
    bus.i_A     = a;
    bus.i_B     = b;
    bus.i_conj  = conj;
    bus.i_valid = valid;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference arithmetic straight from the numeric definition, on plain ints.
  function automatic void model_mul(input logic [15:0] a, input logic [15:0] b, input bit conj,
                                     output logic [15:0] prod, output bit ovf);
    int ar, ai, br, bi, re, im, lo, hi;
    bit cr, ci;
    ar = int'($signed(a[15:8]));
    ai = int'($signed(a[7:0]));
    br = int'($signed(b[15:8]));
    bi = int'($signed(b[7:0]));
    if (conj) begin
      re = ar * br + ai * bi;
      im = ai * br - ar * bi;
    end else begin
      re = ar * br - ai * bi;
      im = ar * bi + ai * br;
    end
    re = (re + (1 << (FW - 1))) >>> FW;
    im = (im + (1 << (FW - 1))) >>> FW;
    hi = (1 << (DW - 1)) - 1;
    lo = -(1 << (DW - 1));
    cr = (re > hi) || (re < lo);
    ci = (im > hi) || (im < lo);
    if (re > hi) re = hi;
    if (re < lo) re = lo;
    if (im > hi) im = hi;
    if (im < lo) im = lo;
    prod = {8'(re), 8'(im)};
    ovf  = cr | ci;
  endfunction

  // One isolated sample with i_ready high: latency must be exactly 3.
  task automatic run_single(input string name, input vec_t v);
    int lat;
    bus.i_ready = 1'b1;
    apply_stimulus(v.a, v.b, v.conj, 1'b1);
    step();
    apply_stimulus(16'h0, 16'h0, 1'b0, 1'b0);
    lat = 1;
    while (!bus.o_valid && lat < 10) begin
      step();
      lat++;
    end
    check_output({name, "_latency"}, 32'(lat), 32'd3);
    check_output({name, "_prod"}, 32'(bus.o_prod), 32'(v.prod));
    check_output({name, "_ovf"}, 32'(bus.o_ovf), 32'(v.ovf));
  endtask

  // Stream n samples from the st_* arrays, optionally with random downstream ready.
  task automatic run_stream(input string name, input int n, input bit rnd_ready,
                            input int max_cycles, output int cycles_used);
    int          sent;
    int          got;
    int          cyc;
    bit          stalled;
    logic [15:0] held_prod;
    bit          held_ovf;
    sent = 0;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held_prod = '0;
    held_ovf = 1'b0;
    while (got < n && cyc < max_cycles) begin
      if (sent < n) apply_stimulus(st_a[sent], st_b[sent], st_c[sent], 1'b1);
      else          apply_stimulus(16'h0, 16'h0, 1'b0, 1'b0);
      bus.i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) begin
        check_output({name, "_hold_valid"}, 32'(bus.o_valid), 32'd1);
        check_output({name, "_hold_prod"}, 32'(bus.o_prod), 32'(held_prod));
        check_output({name, "_hold_ovf"}, 32'(bus.o_ovf), 32'(held_ovf));
      end
      check_output({name, "_o_ready"}, 32'(bus.o_ready), 32'(!bus.o_valid || bus.i_ready));
      if (bus.o_valid && bus.i_ready) begin
        check_output($sformatf("%s_prod%0d", name, got), 32'(bus.o_prod), 32'(st_prod[got]));
        check_output($sformatf("%s_ovf%0d", name, got), 32'(bus.o_ovf), 32'(st_ovf[got]));
        got++;
      end
      stalled   = bus.o_valid && !bus.i_ready;
      held_prod = bus.o_prod;
      held_ovf  = bus.o_ovf;
      if (bus.i_valid && bus.o_ready) sent++;
      @(posedge i_clk);
      #1;
      cyc++;
    end
    check_output({name, "_count"}, 32'(got), 32'(n));
    apply_stimulus(16'h0, 16'h0, 1'b0, 1'b0);
    bus.i_ready = 1'b1;
    cycles_used = cyc;
  endtask

  initial begin
    int   cyc;
    vec_t sat_vec;

    vecs[0] = '{a: 16'h4040, b: 16'h4000, conj: 1'b0, prod: 16'h2020, ovf: 1'b0};
    vecs[1] = '{a: 16'h8000, b: 16'h8000, conj: 1'b0, prod: 16'h7F00, ovf: 1'b1};
    vecs[2] = '{a: 16'h0040, b: 16'h0040, conj: 1'b1, prod: 16'h2000, ovf: 1'b0};
    vecs[3] = '{a: 16'h0040, b: 16'h0040, conj: 1'b0, prod: 16'hE000, ovf: 1'b0};
    vecs[4] = '{a: 16'h0100, b: 16'h4000, conj: 1'b0, prod: 16'h0100, ovf: 1'b0};
    vecs[5] = '{a: 16'hFF00, b: 16'h4000, conj: 1'b0, prod: 16'h0000, ovf: 1'b0};
    vecs[6] = '{a: 16'h7F7F, b: 16'h7F7F, conj: 1'b0, prod: 16'h007F, ovf: 1'b1};
    vecs[7] = '{a: 16'h8080, b: 16'h8080, conj: 1'b1, prod: 16'h7F00, ovf: 1'b1};
    vecs[8] = '{a: 16'h8080, b: 16'h7F80, conj: 1'b0, prod: 16'h8001, ovf: 1'b1};
    vecs[9] = '{a: 16'h2000, b: 16'hC000, conj: 1'b0, prod: 16'hF000, ovf: 1'b0};

    i_rst_n     = 1'b0;
    bus.i_ready = 1'b1;
    apply_stimulus(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) step();
    check_output("reset_o_valid", 32'(bus.o_valid), 32'd0);
    check_output("reset_o_prod", 32'(bus.o_prod), 32'd0);
    check_output("reset_o_ovf", 32'(bus.o_ovf), 32'd0);
    check_output("reset_o_ready", 32'(bus.o_ready), 32'd1);
    i_rst_n = 1'b1;
    step();

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) run_single($sformatf("vec%0d", i), vecs[i]);
    step();

    $display("[TB] back-to-back alternating conj");
    for (int i = 0; i < 4; i++) begin
      st_a[i]    = 16'h0040;
      st_b[i]    = 16'h0040;
      st_c[i]    = (i % 2 == 0);
      st_prod[i] = (i % 2 == 0) ? 16'h2000 : 16'hE000;
      st_ovf[i]  = 1'b0;
    end
    run_stream("alt", 4, 1'b0, 40, cyc);
    check_output("alt_throughput_cycles", 32'(cyc), 32'd7);
    step();

    $display("[TB] random backpressure stream");
    for (int i = 0; i < 20; i++) begin
      st_a[i] = 16'($urandom);
      st_b[i] = 16'($urandom);
      st_c[i] = 1'($urandom_range(0, 1));
      model_mul(st_a[i], st_b[i], st_c[i], st_prod[i], st_ovf[i]);
    end
    run_stream("rnd", 20, 1'b1, 400, cyc);
    step();

    $display("[TB] reset with samples in flight");
    bus.i_ready = 1'b1;
    apply_stimulus(16'h4040, 16'h4000, 1'b0, 1'b1);
    step();
    apply_stimulus(16'h0100, 16'h4000, 1'b0, 1'b1);
    step();
    apply_stimulus(16'h0040, 16'h0040, 1'b1, 1'b1);
    step();
    apply_stimulus(16'h0, 16'h0, 1'b0, 1'b0);
    i_rst_n = 1'b0;
    step();
    check_output("midreset_o_valid", 32'(bus.o_valid), 32'd0);
    check_output("midreset_o_prod", 32'(bus.o_prod), 32'd0);
    check_output("midreset_o_ovf", 32'(bus.o_ovf), 32'd0);
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_output($sformatf("midreset_no_ghost%0d", i), 32'(bus.o_valid), 32'd0);
    end
    sat_vec = '{a: 16'h8000, b: 16'h8000, conj: 1'b0, prod: 16'h7F00, ovf: 1'b1};
    run_single("post_reset", sat_vec);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complex_mul_pipe.md
Name: complex_mul_pipe

Overview:
Pipelined, parametrised signed fixed-point complex multiplier with a valid/ready stream handshake. It is the next generation of the single-cycle combinational complex multiplier used in the FFT datapath (butterfly twiddle multiply). It generalises component width and fraction position, adds rounding, saturation, an overflow flag and a per-sample conjugate mode, and registers the datapath so it closes timing at butterfly clock rates.

Parameters:
DATA_W, 8, width of each real/imag component (two's complement).
FRAC_W, 7, fractional bits per component (Q(DATA_W-FRAC_W).FRAC_W); legal range 1..DATA_W-1.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst_n  in  1  synchronous, active-low reset.
i_valid  in  1  input sample valid.
o_ready  out  1  block can accept an input this cycle.
i_A  in  2*DATA_W  operand A; [2*DATA_W-1:DATA_W] real, [DATA_W-1:0] imag.
i_B  in  2*DATA_W  operand B (twiddle); same packing.
i_conj  in  1  1: compute A*conj(B); 0: A*B. Sampled with the operands.
o_valid  out  1  output sample valid.
i_ready  in  1  downstream accepts output this cycle.
o_prod  out  2*DATA_W  product, same packing and Q format as inputs.
o_ovf  out  1  at least one component of o_prod saturated; qualified by o_valid.

Behaviour:
- Reset (i_rst_n=0 at a rising edge): all stage valid bits, o_valid, o_prod, o_ovf cleared to 0. Reset mid-operation discards all in-flight samples; no output for them.
- Pipeline enable en = !o_valid || i_ready. o_ready = en (combinational). Input transfer when i_valid && o_ready; output transfer when o_valid && i_ready.
- When en=0 every stage, including valid bits, holds. o_prod/o_ovf stay stable while o_valid=1 and i_ready=0.
- Stage 1: register ar, ai, br, bi, conj, valid.
- Stage 2: register four signed products ar*br, ai*bi, ar*bi, ai*br (2*DATA_W bits each), conj, valid.
- Stage 3 (output register): conj=0: re = ar*br - ai*bi, im = ar*bi + ai*br. conj=1: re = ar*br + ai*bi, im = ai*br - ar*bi. Sums are 2*DATA_W+1 bits signed (no internal wrap).
- Rounding: add 2^(FRAC_W-1), then arithmetic shift right by FRAC_W (round half toward +inf).
- Saturation: clamp each component to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; o_ovf = OR of the two components' clamp events.
- Latency: exactly 3 cycles from input transfer to o_valid with i_ready held high; throughput 1 sample/cycle; order preserved.
- Bubbles (i_valid=0 while en=1) propagate as invalid stages; they are not collapsed.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.

Test Plan:
- Basic: W=8,F=7, A=0x4040 (0.5+0.5j), B=0x4000 (0.5), conj=0 -> o_prod=0x2020, o_ovf=0, o_valid exactly 3 cycles after input transfer.
- Saturation: A=0x8000 (-1), B=0x8000 (-1) -> re=+1.0 clamps, o_prod=0x7F00, o_ovf=1.
- Conjugate: A=0x0040, B=0x0040: conj=1 -> 0x2000; conj=0 -> 0xE000; back-to-back with conj alternating per sample, each result matches its own conj bit.
- Rounding: A=0x0100, B=0x4000 -> 0x0100 (64+64>>7 = 1); A=0xFF00, B=0x4000 -> 0x0000.
- Backpressure: stream 20 random samples at i_valid=1 with random i_ready; o_prod stable while stalled, o_ready=0 exactly when o_valid=1 and i_ready=0, no loss/duplication, results match a golden model in order.
- Reset mid-stream: assert i_rst_n=0 for one cycle with 3 samples in flight -> o_valid=0, o_prod=0 the next cycle; those 3 never appear; new input after reset yields result at latency 3.
